// File: rtl/vga_mem_arbiter_if.sv
// Bundle of the VGA read port, CPU read/write port and the BRAM port around the arbiter.
// slave = arbiter side, master = requesters plus memory.
`timescale 1ns/1ps
interface vga_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_ack;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_stall;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  vga_req, vga_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  mem_dout,
        output vga_ack, vga_rvalid, vga_rdata, vga_stall,
        output cpu_ack, cpu_rvalid, cpu_rdata,
        output mem_addr, mem_we, mem_din
    );

    modport master (
        output vga_req, vga_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output mem_dout,
        input  vga_ack, vga_rvalid, vga_rdata, vga_stall,
        input  cpu_ack, cpu_rvalid, cpu_rdata,
        input  mem_addr, mem_we, mem_din
    );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Single-port BRAM arbiter: VGA has fixed priority, a starvation counter forces the CPU
// through after MAX_STALL denied cycles, and a tag pipeline routes read data back (RD_LAT >= 1).
`timescale 1ns/1ps
module vga_mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int RD_LAT    = 1,
    parameter int MAX_STALL = 4
) (
    input  logic             clk,
    input  logic             rst,
    vga_mem_arbiter_if.slave bus
);
    localparam int               CNT_W   = $clog2(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_FORCE = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               vga_grant, cpu_grant;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               vga_stall_q;
    logic [RD_LAT:0]    tag_v_q, tag_cpu_q;
    logic               rd_issue;
    logic [DATA_W-1:0]  vga_rdata_q, cpu_rdata_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_ARB;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        stall_cnt_d = '0;
        if (bus.cpu_req && !cpu_grant) begin
            stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:   if (stall_cnt_d == CNT_MAX) state_d = ST_FORCE;
            // A served or withdrawn CPU request both end the forced slot.
            ST_FORCE: if (cpu_grant || !bus.cpu_req) state_d = ST_ARB;
            default:  state_d = ST_ARB;
        endcase
    end

    // ---------------- FSM: outputs (grant) ----------------
    always_comb begin
        vga_grant = 1'b0;
        cpu_grant = 1'b0;
        if (rst) begin
            if (state_q == ST_FORCE && bus.cpu_req) begin
                cpu_grant = 1'b1;
            end else if (bus.vga_req) begin
                vga_grant = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_grant = 1'b1;
            end
        end
    end

    // ---------------- memory drive ----------------
    always_comb begin
        mem_addr_d = mem_addr_q;
        if (vga_grant) begin
            mem_addr_d = bus.vga_addr;
        end else if (cpu_grant) begin
            mem_addr_d = bus.cpu_addr;
        end
    end

    assign bus.vga_ack  = vga_grant;
    assign bus.cpu_ack  = cpu_grant;
    assign bus.mem_addr = mem_addr_d;
    assign bus.mem_we   = cpu_grant & bus.cpu_we;
    assign bus.mem_din  = bus.cpu_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr_q  <= '0;
            vga_stall_q <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            vga_stall_q <= bus.vga_req & ~vga_grant;
        end
    end

    assign bus.vga_stall = vga_stall_q;

    // ---------------- read tag pipeline ----------------
    // Stage k holds a read acked k+1 cycles ago; stage RD_LAT-1 lines up with mem_dout.
    assign rd_issue = vga_grant | (cpu_grant & ~bus.cpu_we);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_v_q   <= '0;
            tag_cpu_q <= '0;
        end else begin
            tag_v_q   <= {tag_v_q[RD_LAT-1:0], rd_issue};
            tag_cpu_q <= {tag_cpu_q[RD_LAT-1:0], cpu_grant};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else if (tag_v_q[RD_LAT-1]) begin
            if (tag_cpu_q[RD_LAT-1]) begin
                cpu_rdata_q <= bus.mem_dout;
            end else begin
                vga_rdata_q <= bus.mem_dout;
            end
        end
    end

    assign bus.vga_rvalid = tag_v_q[RD_LAT] & ~tag_cpu_q[RD_LAT];
    assign bus.cpu_rvalid = tag_v_q[RD_LAT] &  tag_cpu_q[RD_LAT];
    assign bus.vga_rdata  = vga_rdata_q;
    assign bus.cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Self-checking bench for vga_mem_arbiter: directed scenarios plus a random phase, all
// compared against a cycle-level reference model of the arbitration rules and memory contents.
`timescale 1ns/1ps
module tb_vga_mem_arbiter;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int RD_LAT    = 1;
    localparam int MAX_STALL = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vga_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_STALL(MAX_STALL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // BRAM with one cycle of read latency, 256 words are enough for the address range used
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_din;
        bus.mem_dout <= mem[bus.mem_addr[7:0]];
    end

    // ---------------- reference model state ----------------
    typedef struct {
        int          due;
        bit          to_cpu;
        logic [15:0] data;
    } ret_t;

    ret_t        retq[$];
    logic [15:0] ref_mem [0:255];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          deny = 0;
    bit          prev_vga_denied = 1'b0;
    logic [15:0] exp_vga_rdata = '0;
    logic [15:0] exp_cpu_rdata = '0;
    logic [15:0] exp_mem_addr = '0;
    bit          g_vga = 1'b0;
    bit          g_cpu = 1'b0;
    logic        obs_vga_ack, obs_cpu_ack;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic set_vga(input bit req, input logic [15:0] addr);
        bus.vga_req  = req;
        bus.vga_addr = addr;
    endtask

    task automatic set_cpu(input bit req, input bit we, input logic [15:0] addr, input logic [15:0] wd);
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
    endtask

    task automatic idle();
        set_vga(1'b0, 16'h0);
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // One clock cycle: check every output against the model, then advance the model.
    task automatic tick();
        bit   exp_vr, exp_cr, force_cpu;
        ret_t r;
        @(negedge clk);
        exp_vr = 1'b0;
        exp_cr = 1'b0;
        if (retq.size() > 0 && retq[0].due == cyc) begin
            r = retq.pop_front();
            if (r.to_cpu) begin
                exp_cr = 1'b1;
                exp_cpu_rdata = r.data;
            end else begin
                exp_vr = 1'b1;
                exp_vga_rdata = r.data;
            end
        end
        chk("vga_rvalid", bus.vga_rvalid, exp_vr);
        chk("cpu_rvalid", bus.cpu_rvalid, exp_cr);
        chk("vga_rdata", bus.vga_rdata, exp_vga_rdata);
        chk("cpu_rdata", bus.cpu_rdata, exp_cpu_rdata);
        chk("vga_stall", bus.vga_stall, prev_vga_denied);

        force_cpu = (deny == MAX_STALL) && bus.cpu_req;
        g_cpu = force_cpu || (!bus.vga_req && bus.cpu_req);
        g_vga = bus.vga_req && !force_cpu;
        if (g_vga) exp_mem_addr = bus.vga_addr;
        else if (g_cpu) exp_mem_addr = bus.cpu_addr;

        obs_vga_ack = bus.vga_ack;
        obs_cpu_ack = bus.cpu_ack;
        chk("vga_ack", bus.vga_ack, g_vga);
        chk("cpu_ack", bus.cpu_ack, g_cpu);
        chk("mem_we", bus.mem_we, g_cpu && bus.cpu_we);
        chk("mem_addr", bus.mem_addr, exp_mem_addr);
        if (g_cpu && bus.cpu_we) chk("mem_din", bus.mem_din, bus.cpu_wdata);

        if (g_vga) begin
            retq.push_back('{cyc + RD_LAT + 1, 1'b0, ref_mem[bus.vga_addr[7:0]]});
            $display("txn cyc=%0d vga read  addr=%h exp_data=%h", cyc, bus.vga_addr, ref_mem[bus.vga_addr[7:0]]);
        end else if (g_cpu && bus.cpu_we) begin
            ref_mem[bus.cpu_addr[7:0]] = bus.cpu_wdata;
            $display("txn cyc=%0d cpu write addr=%h data=%h", cyc, bus.cpu_addr, bus.cpu_wdata);
        end else if (g_cpu) begin
            retq.push_back('{cyc + RD_LAT + 1, 1'b1, ref_mem[bus.cpu_addr[7:0]]});
            $display("txn cyc=%0d cpu read  addr=%h exp_data=%h", cyc, bus.cpu_addr, ref_mem[bus.cpu_addr[7:0]]);
        end

        prev_vga_denied = bus.vga_req && !g_vga;
        if (bus.cpu_req && !g_cpu) deny = (deny < MAX_STALL) ? deny + 1 : deny;
        else deny = 0;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Hold reset for n cycles with requests pending; everything must read back as zero.
    task automatic reset_check(input int n);
        rst = 1'b0;
        retq.delete();
        deny = 0;
        prev_vga_denied = 1'b0;
        exp_vga_rdata = '0;
        exp_cpu_rdata = '0;
        exp_mem_addr = '0;
        set_vga(1'b1, 16'h0005);
        set_cpu(1'b1, 1'b1, 16'h0006, 16'hFFFF);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_vga_ack", bus.vga_ack, 0);
            chk("rst_cpu_ack", bus.cpu_ack, 0);
            chk("rst_mem_we", bus.mem_we, 0);
            chk("rst_mem_addr", bus.mem_addr, 0);
            chk("rst_vga_rvalid", bus.vga_rvalid, 0);
            chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
            chk("rst_vga_rdata", bus.vga_rdata, 0);
            chk("rst_cpu_rdata", bus.cpu_rdata, 0);
            chk("rst_vga_stall", bus.vga_stall, 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        idle();
        rst = 1'b1;
    endtask

    initial begin
        bit          vp, cp, cw;
        logic [15:0] va, ca, cd, init_val;

        for (int i = 0; i < 256; i++) begin
            init_val   = 16'(i * 16'h03B1) ^ 16'h5A5A;
            mem[i]     = init_val;
            ref_mem[i] = init_val;
        end
        mem[8'h10]     = 16'hBEEF;
        ref_mem[8'h10] = 16'hBEEF;
        idle();
        @(posedge clk);
        #1;
        reset_check(3);
        tick();

        // CPU-only read of 0xBEEF
        set_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
        tick();
        idle();
        tick();
        chk("t1_cpu_rvalid", bus.cpu_rvalid, 1);
        chk("t1_cpu_rdata", bus.cpu_rdata, 16'hBEEF);
        tick();

        // Write then read-back of the same address in the next cycle
        set_cpu(1'b1, 1'b1, 16'h0020, 16'h1234);
        tick();
        set_cpu(1'b1, 1'b0, 16'h0020, 16'h0);
        tick();
        idle();
        tick();
        chk("t2_cpu_rvalid", bus.cpu_rvalid, 1);
        chk("t2_cpu_rdata", bus.cpu_rdata, 16'h1234);
        tick();
        tick();

        // Continuous VGA traffic against a waiting CPU: forced grant in cycle 4
        cp = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_vga(1'b1, 16'h0040 + 16'(k));
            set_cpu(cp, 1'b0, 16'h0050, 16'h0);
            tick();
            chk("t3_vga_ack", obs_vga_ack, (k != 4));
            chk("t3_cpu_ack", obs_cpu_ack, (k == 4));
            if (g_cpu) cp = 1'b0;
            if (k == 4) chk("t3_vga_stall", bus.vga_stall, 1);
        end
        idle();
        repeat (3) tick();

        // Interleaved reads VGA, CPU, VGA
        set_vga(1'b1, 16'h0001);
        tick();
        set_vga(1'b0, 16'h0);
        set_cpu(1'b1, 1'b0, 16'h0002, 16'h0);
        tick();
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        set_vga(1'b1, 16'h0003);
        tick();
        idle();
        repeat (4) tick();

        // Aborted CPU request under VGA load, then a fresh full-length starvation
        for (int k = 0; k < 2; k++) begin
            set_vga(1'b1, 16'h0060);
            set_cpu(1'b1, 1'b1, 16'h0061, 16'hDEAD);
            tick();
        end
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            set_vga(1'b1, 16'h0062);
            set_cpu(1'b1, 1'b0, 16'h0063, 16'h0);
            tick();
            chk("t6_cpu_ack", obs_cpu_ack, (k == 4));
        end
        idle();
        repeat (3) tick();

        // Reset with a VGA read in flight
        set_vga(1'b1, 16'h0030);
        tick();
        idle();
        reset_check(2);
        repeat (3) tick();
        set_vga(1'b1, 16'h0031);
        tick();
        chk("t5_vga_ack", obs_vga_ack, 1);
        idle();
        tick();
        chk("t5_vga_rvalid", bus.vga_rvalid, 1);
        chk("t5_vga_rdata", bus.vga_rdata, ref_mem[8'h31]);
        tick();

        // Random traffic with handshake-respecting requesters
        vp = 1'b0;
        cp = 1'b0;
        cw = 1'b0;
        va = '0;
        ca = '0;
        cd = '0;
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                reset_check(2);
                vp = 1'b0;
                cp = 1'b0;
            end
            if (!vp && $urandom_range(0, 99) < 55) begin
                vp = 1'b1;
                va = 16'($urandom_range(0, 31));
            end
            if (cp && $urandom_range(0, 19) == 0) begin
                cp = 1'b0;
            end else if (!cp && $urandom_range(0, 99) < 45) begin
                cp = 1'b1;
                cw = 1'($urandom_range(0, 1));
                ca = 16'($urandom_range(0, 31));
                cd = 16'($urandom);
            end
            set_vga(vp, va);
            set_cpu(cp, cw, ca, cd);
            tick();
            if (g_vga) vp = 1'b0;
            if (g_cpu) cp = 1'b0;
        end
        idle();
        repeat (5) tick();
        chk("drain_empty", retq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
